// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage feeding the core.
// Fetches words over imem req/ack into a DEPTH-entry queue; the
// head is offered to the core on instr_valid/instr_ready.
// Ports:
//   clk, reset          clock, sync active-high reset
//   redirect(_pc)       flush queue, restart fetch at redirect_pc
//   imem_req/addr       memory request and word address
//   imem_ack/rdata      memory response (data valid with ack)
//   instr_valid/instr/instr_pc/instr_ready  core handshake
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    fpc_q, fpc_d;
  logic [31:0]    drop_addr_q, drop_addr_d;
  logic [CW-1:0]  count_q, count_d, count_next;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [31:0]    word_q [DEPTH];
  logic [31:0]    pc_q   [DEPTH];
  logic           push, pop;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? word_q[rptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[rptr_q] : '0;
  assign imem_req    = (state_q == REQ) || (state_q == DROP);
  // DROP keeps the abandoned address on the bus until it completes
  assign imem_addr   = (state_q == DROP) ? drop_addr_q : fpc_q;

  assign pop  = instr_valid && instr_ready;
  assign push = (state_q == REQ) && imem_ack && !redirect;
  assign count_next = count_q
                    + {{AW{1'b0}}, push}
                    - {{AW{1'b0}}, pop};

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    drop_addr_d = drop_addr_q;
    count_d     = count_next;
    rptr_d      = pop  ? rptr_q + AW'(1) : rptr_q;
    wptr_d      = push ? wptr_q + AW'(1) : wptr_q;
    if (redirect) begin
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      fpc_d   = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        REQ: begin
          if (imem_ack) begin
            state_d = REQ;
          end else begin
            state_d     = DROP;
            drop_addr_d = fpc_q;
          end
        end
        DROP:    state_d = DROP;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (count_next < CW'(DEPTH)) state_d = REQ;
        end
        REQ: begin
          if (imem_ack) begin
            fpc_d   = fpc_q + 32'd4;
            state_d = (count_next < CW'(DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (imem_ack) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fpc_q       <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rptr_q      <= '0;
      wptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
    end
  end

  // storage needs no reset: outputs are masked while the queue is empty
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wptr_q] <= imem_rdata;
      pc_q[wptr_q]   <= fpc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue with a
// queue-level reference model checked every cycle.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int wait_cnt = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // memory: acks after lat cycles of request, data = addr ^ KEY
  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (reset || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: pending words, fetch pointer, one request
  // in flight (busy), possibly destined for the bin (stale)
  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc = RPC;
  logic [31:0] m_raddr = RPC;
  bit          m_busy = 0;
  bit          m_stale = 0;
  bit          live = 0;
  bit          e_v;
  logic [31:0] e_i, e_p;

  always @(negedge clk) begin
    e_v = mq.size() > 0;
    e_i = e_v ? mq[0].w : 32'h0;
    e_p = e_v ? mq[0].pc : 32'h0;
    if (live) begin
      chk("m_req", {31'b0, imem_req}, {31'b0, m_busy});
      if (m_busy) chk("m_addr", imem_addr, m_raddr);
      chk("m_valid", {31'b0, instr_valid}, {31'b0, e_v});
      chk("m_instr", instr, e_i);
      chk("m_pc", instr_pc, e_p);
    end
    if (reset) begin
      mq.delete();
      m_fpc = RPC;
      m_raddr = RPC;
      m_busy = 0;
      m_stale = 0;
      live = 1;
    end else if (live) begin
      if (e_v && instr_ready) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        m_fpc = {redirect_pc[31:2], 2'b00};
        if (!m_busy) begin
          m_busy = 1;
          m_raddr = m_fpc;
        end else if (!m_stale) begin
          if (imem_ack) m_raddr = m_fpc;
          else m_stale = 1;
        end
      end else if (m_busy && imem_ack) begin
        if (m_stale) begin
          m_stale = 0;
          m_raddr = m_fpc;
        end else begin
          mq.push_back('{w: imem_rdata, pc: m_raddr});
          m_fpc = m_fpc + 32'd4;
          m_busy = mq.size() < DEPTH;
          m_raddr = m_fpc;
        end
      end else if (!m_busy && mq.size() < DEPTH) begin
        m_busy = 1;
        m_raddr = m_fpc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench in C0 (first cycle with reset low)
  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] exp_pc [4];
  logic [31:0] exp_in [4];
  int nreq;

  initial begin
    // reset values
    instr_ready = 1'b1;
    lat = 0;
    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // zero-wait streaming from C2
    reset = 1'b0;
    chk("c0_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("c1_req", {31'b0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("c2_valid", {31'b0, instr_valid}, 32'h1);
    chk("c2_pc", instr_pc, 32'h0);
    chk("c2_instr", instr, 32'hA5A5A5A5);
    tick();
    chk("c3_pc", instr_pc, 32'h4);
    chk("c3_instr", instr, 32'hA5A5A5A1);
    tick();
    chk("c4_pc", instr_pc, 32'h8);
    chk("c4_instr", instr, 32'hA5A5A5AD);

    // core stalled: fill to DEPTH then stop requesting
    instr_ready = 1'b0;
    do_reset();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req && imem_ack) nreq++;
    end
    chk("full_nreq", nreq, 4);
    chk("full_req", {31'b0, imem_req}, 32'h0);
    instr_ready = 1'b1;
    chk("drain_pc0", instr_pc, 32'h0);
    tick();
    chk("drain_pc4", instr_pc, 32'h4);
    chk("resume_req", {31'b0, imem_req}, 32'h1);
    chk("resume_addr", imem_addr, 32'h10);
    tick();
    chk("drain_pc8", instr_pc, 32'h8);
    tick();
    chk("drain_pc12", instr_pc, 32'hC);
    tick();
    chk("drain_pc16", instr_pc, 32'h10);

    // redirect with a 3-cycle request outstanding
    lat = 3;
    do_reset();
    tick();
    chk("drop_c1_addr", imem_addr, 32'h0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("drop_c3_req", {31'b0, imem_req}, 32'h1);
    chk("drop_c3_addr", imem_addr, 32'h0);
    tick();
    chk("drop_c4_ack", {31'b0, imem_ack}, 32'h1);
    chk("drop_c4_addr", imem_addr, 32'h0);
    for (int c = 5; c <= 8; c++) begin
      tick();
      chk("drop_novalid", {31'b0, instr_valid}, 32'h0);
      if (c == 5) chk("drop_newaddr", imem_addr, 32'h100);
    end
    tick();
    chk("drop_c9_valid", {31'b0, instr_valid}, 32'h1);
    chk("drop_c9_pc", instr_pc, 32'h100);
    chk("drop_c9_instr", instr, 32'hA5A5A4A5);

    // redirect together with ack and pop
    lat = 0;
    do_reset();
    tick();
    tick();
    tick();
    chk("rap_pre_valid", {31'b0, instr_valid}, 32'h1);
    chk("rap_pre_ack", {31'b0, imem_ack}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("rap_valid", {31'b0, instr_valid}, 32'h0);
    chk("rap_pc", instr_pc, 32'h0);
    chk("rap_instr", instr, 32'h0);
    chk("rap_addr", imem_addr, 32'h200);
    tick();
    chk("rap_next_pc", instr_pc, 32'h200);

    // address wrap at top of memory
    exp_pc[0] = 32'hFFFFFFF8; exp_in[0] = 32'h5A5A5A5D;
    exp_pc[1] = 32'hFFFFFFFC; exp_in[1] = 32'h5A5A5A59;
    exp_pc[2] = 32'h00000000; exp_in[2] = 32'hA5A5A5A5;
    exp_pc[3] = 32'h00000004; exp_in[3] = 32'hA5A5A5A1;
    do_reset();
    tick();
    tick();
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFF8;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wrap_pc", instr_pc, exp_pc[k]);
      chk("wrap_instr", instr, exp_in[k]);
    end

    // reset with request high and two entries queued
    instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    chk("mr_pre_req", {31'b0, imem_req}, 32'h1);
    chk("mr_pre_pc", instr_pc, 32'h0);
    reset = 1'b1;
    tick();
    chk("mr_req", {31'b0, imem_req}, 32'h0);
    chk("mr_addr", imem_addr, RPC);
    chk("mr_valid", {31'b0, instr_valid}, 32'h0);
    chk("mr_instr", instr, 32'h0);
    chk("mr_pc", instr_pc, 32'h0);
    reset = 1'b0;
    tick();
    chk("mr_restart_req", {31'b0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr, RPC);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage that sits directly upstream of the single-cycle `Mips` core. It fetches 32-bit words from a variable-latency instruction memory over a req/ack handshake and buffers them in a small prefetch queue. It presents instructions, with their PC, to the core over a valid/ready handshake. Branch and jump redirects from the core flush the queue and restart fetch at the new PC.

## Interface
Parameters:
- `DEPTH`, 4: prefetch queue entries; power of two, 2..16.
- `RESET_PC`, 32'h0: fetch address after reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `redirect`, input, 1: flush the queue and restart fetch at `redirect_pc`.
- `redirect_pc`, input, 32: new fetch address; bits [1:0] ignored and forced to 0.
- `imem_req`, output, 1: memory request.
- `imem_addr`, output, 32: word-aligned fetch address; stable while `imem_req` is high.
- `imem_ack`, input, 1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: fetched word.
- `instr_valid`, output, 1: queue head is valid.
- `instr`, output, 32: queue head word; 0 when the queue is empty.
- `instr_pc`, output, 32: address of the queue head; 0 when the queue is empty.
- `instr_ready`, input, 1: core accepts the head this cycle.

## Operation
- Queue: circular buffer of `DEPTH` entries holding {word, pc}, with read and write pointers and a count from 0..`DEPTH`.
- Pointers wrap modulo `DEPTH`.
- Pop happens when `instr_valid && instr_ready`. Push happens when an ack arrives in state REQ.
- The head drives `instr`, `instr_pc` and `instr_valid` directly, combinationally from queue storage.
- At most one request is outstanding. `fpc` is the next fetch address.
- The FSM has three states. `imem_req` is 1 in REQ and DROP only.
  - IDLE: if `count_next < DEPTH`, go to REQ; otherwise stay.
  - REQ: `imem_addr = fpc`. Behaviour on ack:
    - Push {`imem_rdata`, `fpc`} and set `fpc += 4`.
    - Stay in REQ if the post-edge count is below `DEPTH`, so the next request is issued back-to-back.
    - Otherwise go to IDLE.
    - Without an ack, hold REQ and the address.
  - DROP: a redirect occurred while a request was outstanding.
    - Hold `imem_req` high with the old address until `imem_ack`.
    - Discard the returned data, then go to REQ at the redirected `fpc`.
- Redirect (highest priority, any state):
  - Clear the count and both pointers.
  - Set `fpc = {redirect_pc[31:2], 2'b00}`.
  - In REQ with no ack this cycle: go to DROP.
  - In REQ with an ack this cycle: drop the word and go to REQ.
  - In DROP: stay in DROP.
  - In IDLE: go to REQ.
  - A pop handshake in the same cycle is honoured by the core; the queue is cleared regardless.
- `fpc` wraps from 32'hFFFFFFFC to 32'h0.
- Simultaneous push and pop leaves the count unchanged.
- No push ever occurs at count == `DEPTH`, because requests are only issued when a slot is free.
- `imem_rdata` is ignored whenever `imem_ack` arrives outside REQ/DROP; such an ack is a protocol error with no state change.

## Timing
- Reset values:
  - State IDLE, count 0, pointers 0, `fpc` = `RESET_PC`.
  - `imem_req` 0, `imem_addr` = `RESET_PC`.
  - `instr_valid` 0, `instr` 0, `instr_pc` 0.
- Reset mid-transaction abandons the outstanding request; no DROP is entered.
- Counting from the first cycle with `reset` low (C0):
  - IDLE in C0; `imem_req` goes high in C1.
  - An ack in cycle N means the word is pushed at the end of N; `instr_valid` is high in N+1.
- With zero-wait memory (ack in the same cycle as the request), throughput is one word per cycle until the queue is full.
- After a pop frees a slot in IDLE, `imem_req` rises in the next cycle.
- Redirect in cycle R:
  - `instr_valid` is 0 in R+1.
  - The first new request is in R+1 if no request was outstanding; otherwise it is in the cycle after the dropped ack.

## Test plan
- Reset release, zero-wait memory returning `addr ^ 32'hA5A5A5A5`, `instr_ready` = 1 → PCs 0, 4, 8, … delivered one per cycle from C2; each `instr` matches its PC.
- `instr_ready` = 0 with `DEPTH` = 4 → exactly 4 requests issued, then `imem_req` low. Raise `instr_ready` → PCs 0, 4, 8, 12 drain in order and fetching resumes at 16.
- 3-cycle ack latency with redirect to 32'h103 one cycle after request issue → DROP holds the old address until the ack. The next request is to 32'h100, and no pre-redirect word ever reaches the output.
- Redirect in the same cycle as an ack and a pop → queue empty next cycle; the next `instr_pc` is the redirect target.
- Redirect to 32'hFFFFFFF8 → PCs FFFFFFF8, FFFFFFFC, 0, 4 delivered.
- Reset asserted while `imem_req` is high with the queue holding 2 entries → next cycle all outputs are at reset values; fetch restarts at `RESET_PC`.
